// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, mstatus bit positions and FSM states shared by the trap controller
package trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam int MIE_BIT = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI = 12;
  localparam int MPP_LO = 11;
  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    W_STAT,
    MRET_STAT,
    REDIR
  } state_t;
endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap entry / MRET CSR writes and the fetch redirect; TRAP_CTRL_VECTORED_EN enables vectored interrupt targets
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            wb_csr,
  output logic [11:0]     write_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            busy,
  output logic            req_ack,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
  state_t state, next;
  logic [XLEN-1:0] cause_q, epc_q, tval_q, tvec_q, stat_q;
  logic mret_q;
  logic [XLEN-1:0] trap_stat, mret_stat, base, target;
  // Fixed write order for a trap; MRET needs only the mstatus write
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = trap_req ? W_EPC : (mret_req ? MRET_STAT : IDLE);
      W_EPC:     next = W_CAUSE;
      W_CAUSE:   next = W_TVAL;
      W_TVAL:    next = W_STAT;
      W_STAT:    next = REDIR;
      MRET_STAT: next = REDIR;
      default:   next = IDLE;
    endcase
  end
  // State plus a snapshot of the request operands so later input changes cannot leak in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cause_q <= '0;
      epc_q <= '0;
      tval_q <= '0;
      tvec_q <= '0;
      stat_q <= '0;
      mret_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && trap_req) begin
        cause_q <= trap_cause;
        epc_q <= trap_epc;
        tval_q <= trap_tval;
        tvec_q <= mtvec_in;
        stat_q <= mstatus_in;
        mret_q <= 1'b0;
      end else if (state == IDLE && mret_req) begin
        epc_q <= mepc_in;
        stat_q <= mstatus_in;
        mret_q <= 1'b1;
      end
    end
  end
  // mstatus rewrites for trap entry and for MRET; untouched bits pass through
  always_comb begin
    trap_stat = stat_q;
    trap_stat[MPIE_BIT] = stat_q[MIE_BIT];
    trap_stat[MIE_BIT] = 1'b0;
    trap_stat[MPP_HI:MPP_LO] = 2'b11;
    mret_stat = stat_q;
    mret_stat[MIE_BIT] = stat_q[MPIE_BIT];
    mret_stat[MPIE_BIT] = 1'b1;
    mret_stat[MPP_HI:MPP_LO] = 2'b11;
  end
  // Jump target: mtvec base (optionally vectored by interrupt cause) or the saved mepc
  always_comb begin
    base = tvec_q & ALIGN;
`ifdef TRAP_CTRL_VECTORED_EN
    base = (tvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) ? base + {cause_q[XLEN-3:0], 2'b00} : base;
`endif
    target = mret_q ? (epc_q & ALIGN) : base;
  end
  // CSR write port; address and data stay zero outside write states
  always_comb begin
    write_addr = '0;
    csr_wdata = '0;
    case (state)
      W_EPC:     begin write_addr = CSR_MEPC;    csr_wdata = epc_q & ALIGN; end
      W_CAUSE:   begin write_addr = CSR_MCAUSE;  csr_wdata = cause_q;       end
      W_TVAL:    begin write_addr = CSR_MTVAL;   csr_wdata = tval_q;        end
      W_STAT:    begin write_addr = CSR_MSTATUS; csr_wdata = trap_stat;     end
      MRET_STAT: begin write_addr = CSR_MSTATUS; csr_wdata = mret_stat;     end
      default:   begin write_addr = '0;          csr_wdata = '0;            end
    endcase
  end
  assign wb_csr = state inside {W_EPC, W_CAUSE, W_TVAL, W_STAT, MRET_STAT};
  assign busy = state != IDLE;
  assign req_ack = !reset && state == IDLE && (trap_req || mret_req);
  assign redirect_valid = state == REDIR;
  assign redirect_pc = redirect_valid ? target : '0;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized and directed checks of trap_ctrl against a per-transaction expected-output model
module tb_trap_ctrl;
  typedef logic [79:0] obs_t;
  logic clk = 1'b0;
  logic reset, trap_req, mret_req;
  logic [31:0] trap_cause, trap_epc, trap_tval, mstatus_in, mtvec_in, mepc_in;
  logic wb_csr, busy, req_ack, redirect_valid;
  logic [11:0] write_addr;
  logic [31:0] csr_wdata, redirect_pc;
  obs_t obs;
  int total = 0;
  int bad = 0;
  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_tval(trap_tval), .mret_req(mret_req),
    .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .wb_csr(wb_csr), .write_addr(write_addr), .csr_wdata(csr_wdata), .busy(busy),
    .req_ack(req_ack), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  assign obs = {wb_csr, write_addr, csr_wdata, busy, req_ack, redirect_valid, redirect_pc};
  // Issue one request at a negedge and compare every following cycle with the expected output list
  task automatic run_seq(input string tag, input bit is_mret, input logic [31:0] cause, epc, tval, tvec, stat, mepc, input bit both, input bit hold_mret, input bit repulse);
    obs_t q[$];
    logic [31:0] ms, base, tgt;
    q.push_back({1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0});
    if (!is_mret) begin
      ms = (stat & ~32'h1888) | (((stat >> 3) & 32'h1) << 7) | 32'h1800;
      base = tvec - (tvec % 4);
      tgt = base;
`ifdef TRAP_CTRL_VECTORED_EN
      if (tvec % 4 == 1 && cause[31]) tgt = base + 4 * (cause % 32'h8000_0000);
`endif
      q.push_back({1'b1, 12'h341, epc - (epc % 4), 1'b1, 1'b0, 1'b0, 32'h0});
      q.push_back({1'b1, 12'h342, cause, 1'b1, 1'b0, 1'b0, 32'h0});
      q.push_back({1'b1, 12'h343, tval, 1'b1, 1'b0, 1'b0, 32'h0});
      q.push_back({1'b1, 12'h300, ms, 1'b1, 1'b0, 1'b0, 32'h0});
    end else begin
      ms = (stat & ~32'h1888) | (((stat >> 7) & 32'h1) << 3) | 32'h1880;
      tgt = mepc - (mepc % 4);
      q.push_back({1'b1, 12'h300, ms, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    q.push_back({1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b1, tgt});
    @(negedge clk);
    trap_req = !is_mret;
    mret_req = is_mret | both | hold_mret;
    trap_cause = cause;
    trap_epc = epc;
    trap_tval = tval;
    mtvec_in = tvec;
    mstatus_in = stat;
    mepc_in = mepc;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        trap_req = repulse && i == 3;
        mret_req = hold_mret;
        trap_cause = $urandom;
        trap_epc = $urandom;
        trap_tval = $urandom;
        mtvec_in = $urandom;
        mstatus_in = $urandom;
        mepc_in = $urandom;
      end
      #1;
      total++;
      if (obs !== q[i]) begin
        bad++;
        $display("FAIL %s step %0d: got wb/addr/data/busy/ack/rv/pc=%h want %h", tag, i, obs, q[i]);
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    trap_req = 1'b1;
    mret_req = 1'b1;
    trap_cause = $urandom;
    trap_epc = $urandom;
    trap_tval = $urandom;
    mstatus_in = $urandom;
    mtvec_in = $urandom;
    mepc_in = $urandom;
    #2;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(negedge clk);
    reset = 1'b0;
    trap_req = 1'b0;
    mret_req = 1'b0;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL idle_after_reset: got %h want 0", obs); end
  endtask
  task automatic test_directed;
    run_seq("trap_basic", 1'b0, 32'h2, 32'h2000_0012, 32'hDEAD, 32'h0000_0100, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
    run_seq("mret_basic", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1880, 32'h400, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_vectored;
    run_seq("vec_irq", 1'b0, 32'h8000_0007, 32'h44, 32'h0, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    run_seq("vec_exc", 1'b0, 32'h2, 32'h48, 32'h0, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    run_seq("both_trap_wins", 1'b0, 32'h5, 32'h1234_5677, 32'h77, 32'h8000_0040, 32'h88, 32'h900, 1'b1, 1'b1, 1'b0);
    run_seq("held_mret", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80, 32'h606, 1'b0, 1'b0, 1'b0);
    run_seq("b2b_trap_a", 1'b0, 32'hB, 32'h10, 32'h1, 32'h200, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    run_seq("b2b_trap_b", 1'b0, 32'h8000_0003, 32'h20, 32'h2, 32'h301, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_repulse_ignored;
    run_seq("repulse", 1'b0, 32'h4, 32'h3000, 32'h9, 32'h500, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    trap_req = 1'b0;
    mret_req = 1'b0;
    #1;
    total++;
    if ({busy, req_ack, wb_csr} !== 3'b000) begin bad++; $display("FAIL repulse_idle: got busy/ack/wb=%b want 000", {busy, req_ack, wb_csr}); end
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    trap_req = 1'b1;
    trap_cause = 32'h6;
    trap_epc = 32'h700;
    trap_tval = 32'h1;
    mtvec_in = 32'h800;
    mstatus_in = 32'h8;
    @(negedge clk);
    trap_req = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({wb_csr, write_addr} !== {1'b1, 12'h342}) begin bad++; $display("FAIL mid_in_wcause: got wb/addr=%h want 1342", {wb_csr, write_addr}); end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 0", obs); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({redirect_valid, busy, wb_csr} !== 3'b000) begin bad++; $display("FAIL mid_no_redirect cycle %0d: got rv/busy/wb=%b want 000", i, {redirect_valid, busy, wb_csr}); end
    end
  endtask
  task automatic test_random;
    logic [31:0] cause, tvec;
    for (int i = 0; i < 40; i++) begin
      cause = $urandom;
      tvec = $urandom;
      if ($urandom_range(0, 1) == 1) tvec = (tvec & ~32'h3) | 32'h1;
      run_seq($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), cause, $urandom, $urandom, tvec, $urandom, $urandom, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_vectored;
    test_back_to_back;
    test_repulse_ignored;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
